// File: rtl/player_lane_ctrl.sv
// player_lane_ctrl: player column, lives and game-phase tracking for the
// asteroid avoider. Consumes single-cycle key pulses and the collision level.
// All outputs are taken from registered state.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | after reset, waiting for start; keys and hit ignored
//   PLAY  | game running, player moves, a hit costs a life
//   HURT  | invulnerability blanking after a non-fatal hit, still moving
//   OVER  | lives exhausted, column frozen, waiting for start
module player_lane_ctrl #(
    parameter int COLS      = 8,
    parameter int START_COL = 3,
    parameter int LIVES     = 3,
    parameter int HIT_BLANK = 16,
    parameter int CW        = $clog2(COLS)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            left,
    input  logic            right,
    input  logic            start,
    input  logic            hit,
    output logic [CW-1:0]   col,
    output logic [COLS-1:0] col_onehot,
    output logic [3:0]      lives,
    output logic            playing,
    output logic            invuln,
    output logic            game_over,
    output logic            moved
);

    // Blanking counter only ever holds HIT_BLANK-1 down to 0.
    localparam int BW = (HIT_BLANK > 1) ? $clog2(HIT_BLANK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HURT = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [3:0]      lives_q, lives_d;
    logic [BW-1:0]   cnt_q, cnt_d;
    logic            moved_q, moved_d;
    logic [CW-1:0]   col_mv;

    // State register with asynchronous reset back to the idle screen.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            col_q   <= CW'(START_COL);
            lives_q <= 4'(LIVES);
            cnt_q   <= '0;
            moved_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            moved_q <= moved_d;
        end
    end

    // Saturating one-step move; both keys together cancel out.
    always_comb begin
        col_mv = col_q;
        if (left && !right && (col_q != '0)) begin
            col_mv = col_q - 1'b1;
        end else if (right && !left && (col_q != CW'(COLS - 1))) begin
            col_mv = col_q + 1'b1;
        end
    end

    // Next-state logic: phase transitions, lives accounting, blanking timer.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        moved_d = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                // start takes priority over any key pressed in the same cycle
                if (start) begin
                    state_d = S_PLAY;
                    col_d   = CW'(START_COL);
                    lives_d = 4'(LIVES);
                    cnt_d   = '0;
                end
            end
            S_PLAY: begin
                col_d   = col_mv;
                moved_d = (col_mv != col_q);
                if (hit) begin
                    if (lives_q > 4'd1) begin
                        lives_d = lives_q - 4'd1;
                        cnt_d   = BW'(HIT_BLANK - 1);
                        state_d = S_HURT;
                    end else begin
                        lives_d = 4'd0;
                        state_d = S_OVER;
                    end
                end
            end
            S_HURT: begin
                col_d   = col_mv;
                moved_d = (col_mv != col_q);
                // counter runs HIT_BLANK-1 .. 0, so HURT spans HIT_BLANK cycles
                if (cnt_q == '0) begin
                    state_d = S_PLAY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode purely from registered state.
    always_comb begin
        col        = col_q;
        col_onehot = COLS'(1) << col_q;
        lives      = lives_q;
        moved      = moved_q;
        playing    = (state_q == S_PLAY) || (state_q == S_HURT);
        invuln     = (state_q == S_HURT);
        game_over  = (state_q == S_OVER);
    end

endmodule
